// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// instr_sequencer_pkg
//   Shared ISA definitions for the 4-bit microcode processor. The datapath
//   decoder imports the same package, so both sides always agree on:
//     - the jump field bit positions inside an 8-bit instruction
//     - the jump kind codes (JNZ = 2'b01, J = 2'b11)
//     - the sequencer state encoding, which also appears on the debug port
//   Exports: bit-position localparams, kind codes, seq_state_e, is_jump_op().
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

  // Instruction field positions. A jump-class instruction has bit 7 clear and
  // bit 4 set. Bits [6:5] select the kind, and bits [3:0] hold the target.
  localparam int JUMP_N_BIT = 7;
  localparam int JUMP_BIT   = 4;
  localparam int KIND_HI    = 6;
  localparam int KIND_LO    = 5;
  localparam int TGT_HI     = 3;

  localparam logic [1:0] KIND_JNZ = 2'b01;
  localparam logic [1:0] KIND_J   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_e;

  // A jump-class instruction never reaches the datapath.
  function automatic logic is_jump_op(input logic [7:0] ir);
    return ~ir[JUMP_N_BIT] & ir[JUMP_BIT];
  endfunction

endpackage

// File: rtl/instr_sequencer_jump_resolve.sv
// ---------------------------------------------------------------------------
// instr_sequencer_jump_resolve
//   Purely combinational jump resolution. It takes the IR, the current PC and
//   the datapath zero flag, and produces three results:
//     is_jump_o   : the instruction is jump-class (J, JNZ or a jump-class NOP)
//     target_o    : the next PC for this instruction (pc+1 unless taken)
//     self_jump_o : an unconditional J to the current PC (halt condition)
//   Ports: ir_i, pc_i, zero_flag_i in; is_jump_o, target_o, self_jump_o out.
// ---------------------------------------------------------------------------
module instr_sequencer_jump_resolve
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic [INSTR_W-1:0] ir_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               zero_flag_i,
  output logic               is_jump_o,
  output logic [ADDR_W-1:0]  target_o,
  output logic               self_jump_o
);

  logic [1:0]        kind;
  logic [ADDR_W-1:0] field;
  logic [ADDR_W-1:0] pc_inc;

  assign kind   = ir_i[KIND_HI:KIND_LO];
  assign field  = ADDR_W'(ir_i[TGT_HI:0]);
  // The natural overflow of ADDR_W bits gives the modulo wrap.
  assign pc_inc = pc_i + ADDR_W'(1);

  always_comb begin
    is_jump_o   = is_jump_op(ir_i[7:0]);
    target_o    = pc_inc;
    self_jump_o = 1'b0;
    if (is_jump_o) begin
      case (kind)
        KIND_J: begin
          target_o    = field;
          self_jump_o = (field == pc_i);
        end
        KIND_JNZ: begin
          if (!zero_flag_i) target_o = field;
        end
        // Kinds 00 and 10 are jump-class NOPs: fall through to pc+1.
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetch / decode / execute sequencer for the 4-bit microcode processor.
//   This block owns the PC and the IR.
//   - It fetches instructions over a req/ack memory port.
//   - It resolves J and JNZ internally.
//   - It issues every other instruction to the datapath over valid/done.
//
//   Handshakes:
//     mem_req stays high until the cycle in which mem_ack is sampled high.
//     instr_valid stays high until the cycle in which dp_done is sampled high.
//     mem_ack is ignored outside FETCH. dp_done is ignored outside EXEC.
//
//   Ports: clk, rst_n (async, active low), run, mem_req/mem_addr/mem_ack/
//     mem_rdata, instr/instr_valid/dp_done, zero_flag, pc, halted,
//     step (only with SINGLE_STEP_EN), state_dbg (current FSM state).
//
//   Build option SINGLE_STEP_EN: when defined, NEXT stalls until step=1, and
//   the step input port exists. When undefined, NEXT lasts one cycle and the
//   step port is absent.
// ---------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               dp_done,
  input  logic               zero_flag,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output seq_state_e         state_dbg
);

  seq_state_e         state_q,  state_d;
  logic [ADDR_W-1:0]  pc_q,     pc_d;
  logic [INSTR_W-1:0] ir_q,     ir_d;
  logic [ADDR_W-1:0]  target_q, target_d;

  logic              res_is_jump;
  logic [ADDR_W-1:0] res_target;
  logic              res_self_jump;

  instr_sequencer_jump_resolve #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_jump_resolve (
    .ir_i        (ir_q),
    .pc_i        (pc_q),
    .zero_flag_i (zero_flag),
    .is_jump_o   (res_is_jump),
    .target_o    (res_target),
    .self_jump_o (res_self_jump)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      ir_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Decode is the only cycle in which zero_flag is sampled. The target
        // is frozen here so that later changes to zero_flag cannot redirect
        // the jump.
        target_d = res_target;
        if (res_self_jump)    state_d = ST_HALT;
        else if (res_is_jump) state_d = ST_NEXT;
        else                  state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dp_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
`ifdef SINGLE_STEP_EN
        // Dropping run still retires the instruction. Otherwise NEXT waits
        // for step. The PC moves only on the cycle that leaves NEXT.
        if (!run) begin
          pc_d    = target_q;
          state_d = ST_IDLE;
        end else if (step) begin
          pc_d    = target_q;
          state_d = ST_FETCH;
        end
`else
        pc_d    = target_q;
        state_d = run ? ST_FETCH : ST_IDLE;
`endif
      end
      // Halt is sticky: only reset leaves this state, and the PC stays frozen.
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req     = (state_q == ST_FETCH);
  assign mem_addr    = pc_q;
  assign instr       = ir_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       dp_done;
  logic       zero_flag;
  logic [3:0] pc;
  logic       halted;
  seq_state_e state_dbg;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  instr_sequencer #(.ADDR_W(4), .INSTR_W(8), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .dp_done     (dp_done),
    .zero_flag   (zero_flag),
    .pc          (pc),
    .halted      (halted),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .state_dbg   (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- environment: memory and datapath responders ----------------
  logic [7:0] mem [16];
  int mem_lat  = 0;
  int dp_lat   = 0;
  int zf_mode  = 0;   // 0/1: fixed zero_flag, 2: random on each fetch
  bit noise_en = 0;   // spurious ack/done while not requested

  initial begin : mem_responder
    int c;
    c = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    zero_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (c >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          zero_flag = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : (zf_mode != 0);
          c = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          c++;
        end
      end else begin
        mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = 8'($urandom);
        c = 0;
      end
    end
  end

  initial begin : dp_responder
    int c;
    c = 0;
    dp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (c >= dp_lat) begin
          dp_done = 1'b1;
          c = 0;
        end else begin
          dp_done = 1'b0;
          c++;
        end
      end else begin
        dp_done = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        c = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (pc !== 4'd0)          begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if (instr !== 8'h00)      begin errors++; $display("FAIL reset_instr: got %h expected 00", instr); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg); end
    run = 1'b0;
  endtask

  // Two ALU ops, then J 2 at pc=2, which halts.
  task automatic test_program_halt();
    int nvalid;
    int nfetch;
    logic [11:0] seq;
    logic prev_valid;
    fill_mem(8'h80);
    mem[0] = 8'h83; mem[1] = 8'h25; mem[2] = 8'h72;
    mem_lat = 0; dp_lat = 1; zf_mode = 0; noise_en = 0;
    do_reset();
    run = 1'b1;
    nvalid = 0; nfetch = 0; seq = '0; prev_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (mem_req && mem_ack) begin seq = {seq[7:0], mem_addr}; nfetch++; end
      if (instr_valid && !prev_valid) nvalid++;
      prev_valid = instr_valid;
    end
    checks++; if (nvalid != 2)    begin errors++; $display("FAIL halt_issue_count: got %0d expected 2", nvalid); end
    checks++; if (nfetch != 3)    begin errors++; $display("FAIL halt_fetch_count: got %0d expected 3", nfetch); end
    checks++; if (seq !== 12'h012) begin errors++; $display("FAIL halt_fetch_addrs: got %h expected 012", seq); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (pc !== 4'd2)    begin errors++; $display("FAIL halt_pc: got %0d expected 2", pc); end
    checks++; if (instr !== 8'h72) begin errors++; $display("FAIL halt_instr: got %h expected 72", instr); end
    repeat (10) @(negedge clk);
    #1;
    checks++; if (pc !== 4'd2 || halted !== 1'b1 || mem_req !== 1'b0)
      begin errors++; $display("FAIL halt_sticky: got pc=%0d halted=%b req=%b expected 2/1/0", pc, halted, mem_req); end
    run = 1'b0;
  endtask

  // NOPs at 0..2, JNZ 5 at 3. Taken when zero_flag=0 (pc=5), not taken when
  // zero_flag=1 (pc=4). Both destinations hold a self-jump that halts.
  task automatic test_jnz();
    for (int zf = 0; zf < 2; zf++) begin
      int nvalid;
      int t0;
      int t1;
      int nfetch;
      logic [19:0] seq;
      logic [3:0] exp_t;
      fill_mem(8'h10);
      mem[3] = 8'h35; mem[4] = 8'h74; mem[5] = 8'h75;
      mem_lat = 0; dp_lat = 0; zf_mode = zf; noise_en = 0;
      exp_t = (zf == 0) ? 4'd5 : 4'd4;
      do_reset();
      run = 1'b1;
      nvalid = 0; nfetch = 0; seq = '0; t0 = 0; t1 = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (mem_req && mem_ack) begin
          if (nfetch == 0) t0 = cyc;
          if (nfetch == 1) t1 = cyc;
          seq = {seq[15:0], mem_addr};
          nfetch++;
        end
        if (instr_valid) nvalid++;
      end
      checks++; if (pc !== exp_t)    begin errors++; $display("FAIL jnz_pc zf=%0d: got %0d expected %0d", zf, pc, exp_t); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL jnz_halt zf=%0d: got %b expected 1", zf, halted); end
      checks++; if (nvalid != 0)     begin errors++; $display("FAIL jnz_no_issue zf=%0d: got %0d expected 0", zf, nvalid); end
      checks++; if (seq !== {16'h0123, exp_t}) begin errors++; $display("FAIL jnz_fetch_addrs zf=%0d: got %h expected %h", zf, seq, {16'h0123, exp_t}); end
      checks++; if (t1 - t0 != 3)    begin errors++; $display("FAIL jnz_jump_latency zf=%0d: got %0d expected 3", zf, t1 - t0); end
      run = 1'b0;
    end
  endtask

  // J 15 at 0, then an ALU op at 15. The PC must wrap to 0, and a zero-wait
  // non-jump takes 4 cycles.
  task automatic test_wrap();
    int nfetch;
    int t[3];
    logic [11:0] seq;
    fill_mem(8'h80);
    mem[0] = 8'h7F; mem[15] = 8'h80;
    mem_lat = 0; dp_lat = 0; zf_mode = 0; noise_en = 0;
    do_reset();
    run = 1'b1;
    nfetch = 0; seq = '0;
    for (int i = 0; i < 3; i++) t[i] = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (mem_req && mem_ack) begin
        if (nfetch < 3) begin t[nfetch] = cyc; seq = {seq[7:0], mem_addr}; end
        nfetch++;
      end
    end
    checks++; if (seq !== 12'h0F0)    begin errors++; $display("FAIL wrap_fetch_addrs: got %h expected 0f0", seq); end
    checks++; if (t[2] - t[1] != 4)   begin errors++; $display("FAIL wrap_nonjump_latency: got %0d expected 4", t[2] - t[1]); end
    checks++; if (t[1] - t[0] != 3)   begin errors++; $display("FAIL wrap_jump_latency: got %0d expected 3", t[1] - t[0]); end
    run = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0 || state_dbg !== ST_IDLE)
      begin errors++; $display("FAIL wrap_stop: got req=%b state=%0d expected 0/IDLE", mem_req, state_dbg); end
  endtask

  // Slow memory (ack after 3 wait cycles) and slow datapath (done after 5).
  task automatic test_stall();
    int req_cycles;
    int valid_cycles;
    int ir_changes;
    int addr_bad;
    bit first_done;
    logic [7:0] prev_ir;
    fill_mem(8'h80);
    mem[0] = 8'h81; mem[1] = 8'h71;
    mem_lat = 3; dp_lat = 5; zf_mode = 0; noise_en = 0;
    do_reset();
    run = 1'b1;
    req_cycles = 0; valid_cycles = 0; ir_changes = 0; addr_bad = 0;
    first_done = 0; prev_ir = instr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (!first_done && mem_req) begin
        req_cycles++;
        if (mem_addr !== 4'd0) addr_bad++;
        if (mem_ack) first_done = 1;
      end
      if (instr_valid) valid_cycles++;
      if (instr !== prev_ir) ir_changes++;
      prev_ir = instr;
    end
    checks++; if (req_cycles != 4)   begin errors++; $display("FAIL stall_req_held: got %0d expected 4", req_cycles); end
    checks++; if (addr_bad != 0)     begin errors++; $display("FAIL stall_addr_stable: got %0d bad expected 0", addr_bad); end
    checks++; if (valid_cycles != 6) begin errors++; $display("FAIL stall_valid_held: got %0d expected 6", valid_cycles); end
    checks++; if (ir_changes != 2)   begin errors++; $display("FAIL stall_ir_loads: got %0d expected 2", ir_changes); end
    checks++; if (pc !== 4'd1 || halted !== 1'b1)
      begin errors++; $display("FAIL stall_end: got pc=%0d halted=%b expected 1/1", pc, halted); end
    run = 1'b0;
  endtask

  // run drops during EXEC, then asynchronous reset mid-fetch.
  task automatic test_run_drop_and_reset();
    int waited;
    int extra_fetch;
    fill_mem(8'h80);
    mem[0] = 8'h82;
    mem_lat = 0; dp_lat = 3; zf_mode = 0; noise_en = 0;
    do_reset();
    run = 1'b1;
    waited = 0;
    while (instr_valid !== 1'b1 && waited < 20) begin @(negedge clk); #1; waited++; end
    checks++; if (waited >= 20) begin errors++; $display("FAIL rundrop_exec_timeout: got no instr_valid within %0d cycles", waited); end
    run = 1'b0;
    extra_fetch = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (mem_req) extra_fetch++;
    end
    checks++; if (pc !== 4'd1)         begin errors++; $display("FAIL rundrop_pc: got %0d expected 1", pc); end
    checks++; if (extra_fetch != 0)    begin errors++; $display("FAIL rundrop_no_fetch: got %0d expected 0", extra_fetch); end
    checks++; if (state_dbg !== ST_IDLE || instr_valid !== 1'b0)
      begin errors++; $display("FAIL rundrop_idle: got state=%0d valid=%b expected IDLE/0", state_dbg, instr_valid); end
    mem_lat = 6;
    run = 1'b1;
    waited = 0;
    while (mem_req !== 1'b1 && waited < 20) begin @(negedge clk); #1; waited++; end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 4'd1)
      begin errors++; $display("FAIL midfetch_req: got req=%b addr=%0d expected 1/1", mem_req, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== 4'd0 || instr !== 8'h00)
      begin errors++; $display("FAIL async_reset: got req=%b pc=%0d instr=%h expected 0/0/00", mem_req, pc, instr); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random program with random latencies, random zero_flag and spurious
  // ack/done. An ISA-level model predicts every fetch address and every
  // instruction issued to the datapath.
  task automatic test_random();
    logic [7:0] v;
    logic [3:0] exp_pc;
    logic [7:0] exp_ir;
    logic [7:0] ir;
    logic [7:0] got;
    logic [7:0] exp_q[$];
    int nfetch;
    bit done;
    for (int a = 0; a < 16; a++) begin
      v = 8'($urandom);
      // A J to its own address would halt the run early, so retarget it.
      if (!v[7] && v[4] && v[6:5] == 2'b11 && v[3:0] == 4'(a)) v[3:0] = 4'(a + 1);
      mem[a] = v;
    end
    mem_lat = 0; dp_lat = 0; zf_mode = 2; noise_en = 1;
    do_reset();
    run = 1'b1;
    exp_pc = 4'd0; exp_ir = 8'h00; nfetch = 0; done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk); #1;
      checks++; if (instr !== exp_ir) begin errors++; $display("FAIL rand_instr_hold: got %h expected %h", instr, exp_ir); end
      if (halted) begin checks++; errors++; $display("FAIL rand_halted: got 1 expected 0"); end
      if (instr_valid && dp_done) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_issue: got unexpected %h expected none", instr); end
        else begin
          got = exp_q.pop_front();
          if (instr !== got) begin errors++; $display("FAIL rand_issue: got %h expected %h", instr, got); end
        end
      end
      if (mem_req && mem_ack) begin
        checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL rand_fetch_addr: got %0d expected %0d", mem_addr, exp_pc); end
        ir = mem[exp_pc];
        exp_ir = ir;
        if (ir[7] || !ir[4]) exp_q.push_back(ir);
        if (!ir[7] && ir[4] && ir[6:5] == 2'b11)               exp_pc = ir[3:0];
        else if (!ir[7] && ir[4] && ir[6:5] == 2'b01 && !zero_flag) exp_pc = ir[3:0];
        else                                                    exp_pc = exp_pc + 4'd1;
        nfetch++;
        mem_lat = $urandom_range(0, 3);
        dp_lat  = $urandom_range(0, 3);
        if (nfetch == 80) run = 1'b0;
      end
      if (nfetch >= 80 && state_dbg == ST_IDLE) done = 1;
    end
    checks++; if (!done)             begin errors++; $display("FAIL rand_timeout: got %0d fetches expected 80 then idle", nfetch); end
    checks++; if (nfetch != 80)      begin errors++; $display("FAIL rand_fetch_count: got %0d expected 80", nfetch); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending: got %0d left expected 0", exp_q.size()); end
    checks++; if (pc !== exp_pc)     begin errors++; $display("FAIL rand_final_pc: got %0d expected %0d", pc, exp_pc); end
    noise_en = 0;
  endtask

`ifdef SINGLE_STEP_EN
  // With step held low, NEXT stalls. Each step pulse advances the PC once.
  task automatic test_single_step();
    fill_mem(8'h10);
    mem_lat = 0; dp_lat = 0; zf_mode = 0; noise_en = 0;
    step = 1'b0;
    do_reset();
    run = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    checks++; if (pc !== 4'd0 || state_dbg !== ST_NEXT)
      begin errors++; $display("FAIL step_stall: got pc=%0d state=%0d expected 0/NEXT", pc, state_dbg); end
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      @(negedge clk); #1;
      step = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (pc !== 4'(k)) begin errors++; $display("FAIL step_advance %0d: got %0d expected %0d", k, pc, k); end
    end
    run = 1'b0;
    step = 1'b1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    run = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    fill_mem(8'h80);
    test_reset();
    test_program_halt();
    test_jnz();
    test_wrap();
    test_stall();
    test_run_drop_and_reset();
    test_random();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
